// File: rtl/cymometer_pkg.sv
// cymometer_pkg: shared 7-segment constants and display helpers for the frequency meter.
package cymometer_pkg;
    localparam int NDIG  = 8;
    localparam int BCD_W = 4;
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_MINUS = 7'h40;
    localparam logic [6:0] SEG_OFF   = 7'h00;

    function automatic logic [7:0] to_level(input logic [7:0] v, input logic act_low);
        return act_low ? ~v : v;
    endfunction
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-high {g..a} pattern; invalid codes show a minus.
module bcd_to_seg7
    import cymometer_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_o
);
    always_comb begin
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_MINUS;
        endcase
    end
endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: double-buffered, time-multiplexed 8-digit 7-segment driver
// with optional leading-zero blanking.
module seg7_scan_display
    import cymometer_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit SCAN_ACT_LOW = 1'b1
) (
    input  logic        sysclk,
    input  logic        rst,
    input  logic [31:0] bcd_in,
    input  logic        bcd_valid,
    input  logic        blank_lz,
    output logic [6:0]  seg7,
    output logic [7:0]  scan,
    output logic        frame_done
);
    localparam int DIV = CLK_HZ / SCAN_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [6:0] SEG_RST  = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [7:0] SCAN_RST = SCAN_ACT_LOW ? 8'hFF : 8'h00;

    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      disp_q, disp_d, pend_q, pend_d;
    logic             pend_flag_q, pend_flag_d;
    logic [6:0]       seg7_q;
    logic [7:0]       scan_q;
    logic             frame_done_q;
    logic             tick, boundary, blank;
    logic [NDIG-1:0]  lz;
    logic [BCD_W-1:0] dig;
    logic [6:0]       seg_dec, seg_lg;
    logic [7:0]       seg_pol, scan_pol;

    assign tick     = cnt_q == CW'(DIV - 1);
    assign boundary = tick && idx_q == 3'(NDIG - 1);

    always_comb begin
        cnt_d       = tick ? '0 : cnt_q + CW'(1);
        idx_d       = tick ? idx_q + 3'd1 : idx_q;
        disp_d      = boundary ? (bcd_valid ? bcd_in : pend_flag_q ? pend_q : disp_q) : disp_q;
        pend_d      = bcd_valid ? bcd_in : pend_q;
        pend_flag_d = !boundary && (bcd_valid || pend_flag_q);
    end

    // lz[i]: digit i and every digit above it are zero in the value about to be shown
    always_comb begin
        lz = '0;
        lz[NDIG-1] = disp_d[(NDIG-1)*BCD_W +: BCD_W] == '0;
        for (int i = NDIG - 2; i >= 0; i--)
            lz[i] = lz[i+1] && disp_d[i*BCD_W +: BCD_W] == '0;
    end

    assign dig   = disp_d[{idx_d, 2'b00} +: BCD_W];
    assign blank = blank_lz && idx_d != 3'd0 && lz[idx_d];

    bcd_to_seg7 u_dec (
        .bcd_i (dig),
        .seg_o (seg_dec)
    );

    assign seg_lg   = blank ? SEG_OFF : seg_dec;
    assign seg_pol  = to_level({1'b0, seg_lg}, SEG_ACT_LOW);
    assign scan_pol = to_level(8'd1 << idx_d, SCAN_ACT_LOW);

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            disp_q       <= '0;
            pend_q       <= '0;
            pend_flag_q  <= 1'b0;
            seg7_q       <= SEG_RST;
            scan_q       <= SCAN_RST;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            disp_q       <= disp_d;
            pend_q       <= pend_d;
            pend_flag_q  <= pend_flag_d;
            frame_done_q <= boundary;
            if (tick) begin
                seg7_q <= seg_pol[6:0];
                scan_q <= scan_pol;
            end
        end
    end

    assign seg7       = seg7_q;
    assign scan       = scan_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display: random and directed stimulus; a cycle-level reference model
// feeds a scoreboard queue that a separate monitor drains and compares.
module tb_seg7_scan_display;
    logic        sysclk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] bcd_in = '0;
    logic        bcd_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg7;
    logic [7:0]  scan;
    logic        frame_done;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic [7:0] scan;
        logic       fd;
    } exp_t;
    exp_t exp_q[$];

    seg7_scan_display #(.CLK_HZ(80), .SCAN_HZ(10), .SEG_ACT_LOW(1'b1), .SCAN_ACT_LOW(1'b1)) dut (
        .sysclk     (sysclk),
        .rst        (rst),
        .bcd_in     (bcd_in),
        .bcd_valid  (bcd_valid),
        .blank_lz   (blank_lz),
        .seg7       (seg7),
        .scan       (scan),
        .frame_done (frame_done)
    );

    always #5 sysclk = ~sysclk;

    logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

    function automatic logic [6:0] pattern(input logic [31:0] v, input int n, input logic blz);
        logic [31:0] above;
        above = v >> (4 * n);
        if (blz && n > 0 && above == 0) return 7'h00;
        return tab[above[3:0]];
    endfunction

    // Reference model: time since reset decides ticks (every 8 cycles) and frames (every 64).
    int          cyc = 0;
    logic [31:0] m_disp, m_pend;
    logic        m_flag;
    exp_t        m_out;
    initial begin
        forever begin
            @(posedge sysclk);
            if (rst) begin
                cyc = 0; m_disp = 0; m_pend = 0; m_flag = 0;
                m_out = '{seg: 7'h7F, scan: 8'hFF, fd: 1'b0};
            end else begin
                if (cyc % 64 == 63 && bcd_valid) begin
                    m_disp = bcd_in; m_flag = 0;
                end else if (cyc % 64 == 63 && m_flag) begin
                    m_disp = m_pend; m_flag = 0;
                end else if (bcd_valid) begin
                    m_pend = bcd_in; m_flag = 1;
                end
                m_out.fd = 1'b0;
                if (cyc % 8 == 7) begin
                    int n;
                    n = (cyc / 8 + 1) % 8;
                    m_out.scan = ~(8'd1 << n);
                    m_out.seg  = ~pattern(m_disp, n, blank_lz);
                    m_out.fd   = (cyc % 64 == 63);
                end
                cyc++;
            end
            exp_q.push_back(m_out);
        end
    end

    initial begin
        forever begin
            @(negedge sysclk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (seg7 !== e.seg || scan !== e.scan || frame_done !== e.fd) begin
                    errors++;
                    $display("FAIL outputs t=%0t: got seg7=%h scan=%h fd=%b, want seg7=%h scan=%h fd=%b",
                             $time, seg7, scan, frame_done, e.seg, e.scan, e.fd);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge sysclk);
        #1;
    endtask

    task automatic strobe(input logic [31:0] v);
        @(negedge sysclk); #1;
        bcd_in = v; bcd_valid = 1'b1;
        @(negedge sysclk); #1;
        bcd_valid = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        while (cyc % 64 != ph) @(negedge sysclk);
        #1;
    endtask

    initial begin
        cycles(3);
        rst = 1'b0;
        cycles(140);
        wait_phase(20);
        strobe(32'h1234_5678);
        cycles(140);
        blank_lz = 1'b1;
        strobe(32'h0000_0105);
        cycles(140);
        strobe(32'h0000_0000);
        cycles(140);
        blank_lz = 1'b0;
        wait_phase(63);
        bcd_in = 32'h9999_9999; bcd_valid = 1'b1;
        cycles(1);
        bcd_valid = 1'b0;
        cycles(10);
        strobe(32'h1111_2222);
        strobe(32'h3456_7890);
        cycles(140);
        blank_lz = 1'b1;
        strobe(32'h0000_C000);
        cycles(140);
        strobe(32'h0AB0_0007);
        cycles(140);
        for (int k = 0; k < 25; k++) begin
            logic [31:0] v;
            v = $urandom;
            if ($urandom_range(0, 1) == 1) v = v >> (4 * $urandom_range(1, 7));
            blank_lz = 1'($urandom_range(0, 1));
            cycles($urandom_range(0, 90));
            strobe(v);
        end
        cycles(140);
        blank_lz = 1'b0;
        strobe(32'h8765_4321);
        cycles(140);
        wait_phase(36);
        strobe(32'h5555_5555);
        rst = 1'b1;
        #1;
        checks++;
        if (seg7 !== 7'h7F || scan !== 8'hFF || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got seg7=%h scan=%h fd=%b, want seg7=7f scan=ff fd=0",
                     seg7, scan, frame_done);
        end
        cycles(3);
        rst = 1'b0;
        cycles(200);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
